mdu_seq_ctrl: RTL

//  Multi-cycle RV32M sequencer for unsigned MUL/MULHU/DIVU/REMU. Drives one

---
 rtl/mdu_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer driving one external 32-bit adder.
// Shift-add multiply and restoring divide each take one adder pass per cycle for 32 cycles.
module mdu_seq_ctrl #(
   parameter int XLEN      = 32,
   parameter bit DIV0_FAST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [XLEN-1:0] add_a,
   output logic [XLEN-1:0] add_b,
   output logic            add_cin,
   input  logic [XLEN-1:0] add_sum,
   input  logic            add_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   state_e          state_q;
   op_e             op_q;
   logic [4:0]      cnt_q;
   logic [XLEN-1:0] opnd_q;   // multiplicand for MUL ops, divisor for DIV ops
   logic [XLEN-1:0] acc_q;    // hi for MUL ops, remainder for DIV ops
   logic [XLEN-1:0] shf_q;    // lo for MUL ops, quotient for DIV ops
   logic            req_ready_q;
   logic            resp_valid_q;
   logic [XLEN-1:0] resp_data_q;

   logic [XLEN-1:0] acc_d;
   logic [XLEN-1:0] shf_d;
   logic [XLEN-1:0] result_d;
   logic [XLEN-1:0] div_t;
   logic            qbit;
   logic            req_is_div;
   logic            req_div0;

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

   assign req_is_div = req_op[1];
   assign req_div0   = DIV0_FAST && req_is_div && (req_b == '0);
   assign div_t      = {acc_q[XLEN-2:0], shf_q[XLEN-1]};

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;
      qbit     = 1'b0;
      acc_d    = acc_q;
      shf_d    = shf_q;
      result_d = '0;
      if (state_q == S_RUN) begin
         if (!op_q[1]) begin
            add_a = acc_q;
            add_b = shf_q[0] ? opnd_q : '0;
            {acc_d, shf_d} = {add_cout, add_sum, shf_q[XLEN-1:1]};
         end else begin
            // Subtract via ~divisor + 1; a set rem MSB means the 33-bit partial remainder already exceeds the divisor.
            add_a   = div_t;
            add_b   = ~opnd_q;
            add_cin = 1'b1;
            if (acc_q[XLEN-1] | add_cout) begin
               acc_d = add_sum;
               qbit  = 1'b1;
            end else begin
               acc_d = div_t;
            end
            shf_d = {shf_q[XLEN-2:0], qbit};
         end
      end
      case (op_q)
         OP_MUL:   result_d = shf_d;
         OP_MULHU: result_d = acc_d;
         OP_DIVU:  result_d = shf_d;
         OP_REMU:  result_d = acc_d;
         default:  result_d = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_MUL;
         cnt_q        <= '0;
         opnd_q       <= '0;
         acc_q        <= '0;
         shf_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= op_e'(req_op);
                  opnd_q      <= req_is_div ? req_b : req_a;
                  shf_q       <= req_is_div ? req_a : req_b;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  if (req_div0) begin
                     state_q      <= S_DONE;
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= (req_op == OP_DIVU) ? '1 : req_a;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               shf_q <= shf_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q      <= S_DONE;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= result_d;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule
